// File: rtl/zn_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// zn_fetch_sequencer
// Instruction fetch sequencer: requests one instruction at a time from
// instruction memory, offers it to the decoder with a valid/ready handshake,
// and handles jump/branch redirects and halts.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   o_imem_req / o_imem_addr  instruction-memory request and address
//   i_imem_ack / i_imem_rdata memory response (data valid with ack)
//   o_instr_valid / o_instr / o_instr_pc / i_instr_ready
//                             decoder-side offer and handshake
//   i_redirect / i_redirect_pc  jump/branch to a new pc
//   i_halt / o_halted         stop-fetch request and halted status
//   o_issue_cnt               count of instructions accepted by the decoder
// ---------------------------------------------------------------------------
module zn_fetch_sequencer #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned INSTR_W     = 16,
    parameter int unsigned INSTR_BYTES = 2,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic               o_imem_req,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic               i_imem_ack,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic               o_instr_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_instr_pc,
    input  logic               i_instr_ready,
    input  logic               i_redirect,
    input  logic [ADDR_W-1:0]  i_redirect_pc,
    input  logic               i_halt,
    output logic               o_halted,
    output logic [CNT_W-1:0]   o_issue_cnt
);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSTR_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_RST     = ADDR_W'(RESET_PC);

    logic [1:0]         r_state,     w_state_nxt;
    logic [ADDR_W-1:0]  r_pc,        w_pc_nxt;
    logic               r_squash,    w_squash_nxt;
    logic               r_halt_pend, w_halt_pend_nxt;
    logic               r_req,       w_req_nxt;
    logic [ADDR_W-1:0]  r_addr,      w_addr_nxt;
    logic               r_valid,     w_valid_nxt;
    logic [INSTR_W-1:0] r_instr,     w_instr_nxt;
    logic [ADDR_W-1:0]  r_instr_pc,  w_instr_pc_nxt;
    logic               r_halted,    w_halted_nxt;
    logic [CNT_W-1:0]   r_cnt,       w_cnt_nxt;
    logic [ADDR_W-1:0]  w_tgt;

    // Redirect target aligned to an instruction boundary
    assign w_tgt = i_redirect_pc & ALIGN_MASK;

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_FETCH;
            r_pc        <= PC_RST;
            r_squash    <= 1'b0;
            r_halt_pend <= 1'b0;
            r_req       <= 1'b0;
            r_addr      <= PC_RST;
            r_valid     <= 1'b0;
            r_instr     <= '0;
            r_instr_pc  <= '0;
            r_halted    <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_squash    <= w_squash_nxt;
            r_halt_pend <= w_halt_pend_nxt;
            r_req       <= w_req_nxt;
            r_addr      <= w_addr_nxt;
            r_valid     <= w_valid_nxt;
            r_instr     <= w_instr_nxt;
            r_instr_pc  <= w_instr_pc_nxt;
            r_halted    <= w_halted_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_squash_nxt    = r_squash;
        w_halt_pend_nxt = r_halt_pend;
        w_req_nxt       = r_req;
        w_addr_nxt      = r_addr;
        w_valid_nxt     = r_valid;
        w_instr_nxt     = r_instr;
        w_instr_pc_nxt  = r_instr_pc;
        w_halted_nxt    = r_halted;
        w_cnt_nxt       = r_cnt;

        case (r_state)
            S_FETCH: begin
                if (!r_req) begin
                    // Only reached out of reset: no request is outstanding yet
                    if (i_redirect) begin
                        w_pc_nxt   = w_tgt;
                        w_addr_nxt = w_tgt;
                        w_req_nxt  = 1'b1;
                    end else if (i_halt) begin
                        w_state_nxt  = S_HALTED;
                        w_halted_nxt = 1'b1;
                    end else begin
                        w_addr_nxt = r_pc;
                        w_req_nxt  = 1'b1;
                    end
                end else if (i_imem_ack) begin
                    w_squash_nxt    = 1'b0;
                    w_halt_pend_nxt = 1'b0;
                    if (i_redirect) begin
                        // Response discarded; request again at the target
                        w_pc_nxt   = w_tgt;
                        w_addr_nxt = w_tgt;
                    end else if (r_halt_pend || i_halt) begin
                        w_state_nxt  = S_HALTED;
                        w_req_nxt    = 1'b0;
                        w_halted_nxt = 1'b1;
                    end else if (r_squash) begin
                        // Stale response from before a redirect
                        w_addr_nxt = r_pc;
                    end else begin
                        w_instr_nxt    = i_imem_rdata;
                        w_instr_pc_nxt = r_pc;
                        w_pc_nxt       = r_pc + PC_INC;
                        w_state_nxt    = S_ISSUE;
                        w_valid_nxt    = 1'b1;
                        w_req_nxt      = 1'b0;
                    end
                end else begin
                    // Request in flight: address held, remember what to do at ack
                    if (i_redirect) begin
                        w_pc_nxt        = w_tgt;
                        w_squash_nxt    = 1'b1;
                        w_halt_pend_nxt = 1'b0;
                    end else if (i_halt) begin
                        w_halt_pend_nxt = 1'b1;
                    end
                end
            end

            S_ISSUE: begin
                if (i_redirect) begin
                    if (i_instr_ready) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                    w_valid_nxt = 1'b0;
                    w_pc_nxt    = w_tgt;
                    w_addr_nxt  = w_tgt;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if (i_instr_ready) begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_valid_nxt = 1'b0;
                    if (i_halt) begin
                        w_state_nxt  = S_HALTED;
                        w_halted_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_addr_nxt  = r_pc;
                        w_req_nxt   = 1'b1;
                    end
                end
            end

            S_HALTED: begin
                if (i_redirect) begin
                    w_state_nxt  = S_FETCH;
                    w_halted_nxt = 1'b0;
                    w_pc_nxt     = w_tgt;
                    w_addr_nxt   = w_tgt;
                    w_req_nxt    = 1'b1;
                end
            end

            default: begin
                w_state_nxt  = S_FETCH;
                w_req_nxt    = 1'b0;
                w_valid_nxt  = 1'b0;
                w_halted_nxt = 1'b0;
                w_squash_nxt = 1'b0;
            end
        endcase
    end

    assign o_imem_req    = r_req;
    assign o_imem_addr   = r_addr;
    assign o_instr_valid = r_valid;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_halted      = r_halted;
    assign o_issue_cnt   = r_cnt;

endmodule

// File: tb/tb_zn_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_zn_fetch_sequencer
// Self-checking bench: directed scenarios plus a randomized run against a
// program-order reference model (expected next pc, accept count).
// ---------------------------------------------------------------------------
module tb_zn_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] rpc = 16'h0000;
    logic        halt = 1'b0;
    logic        halted;
    logic [3:0]  issue_cnt;

    int checks = 0;
    int failures = 0;
    int lat = 1;
    int mcnt = 0;
    logic acked;
    logic [15:0] ack_addrs[$];

    zn_fetch_sequencer #(
        .ADDR_W(16), .INSTR_W(16), .INSTR_BYTES(2), .RESET_PC(0), .CNT_W(4)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
        .o_instr_valid(instr_valid), .o_instr(instr), .o_instr_pc(instr_pc),
        .i_instr_ready(ready), .i_redirect(redirect), .i_redirect_pc(rpc),
        .i_halt(halt), .o_halted(halted), .o_issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    // Program image: word at a is 0x1111 * (a/2 + 1)
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] k;
        k = (a >> 1) + 16'd1;
        return 16'h1111 * k;
    endfunction

    // Memory: ack after 'lat' cycles of a request, one request at a time
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            imem_ack = 1'b0;
            mcnt = 0;
        end else begin
            acked = imem_ack;
            imem_ack = 1'b0;
            if (!imem_req) mcnt = 0;
            else if (acked) mcnt = 1;
            else if (mcnt >= lat) begin
                imem_ack = 1'b1;
                imem_rdata = mem_word(imem_addr);
                ack_addrs.push_back(imem_addr);
            end else mcnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0; ready = 1'b0; redirect = 1'b0; halt = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: req=%b valid=%b halted=%b want 0 0 0", imem_req, instr_valid, halted);
        end
        checks++;
        if (instr !== 16'h0 || instr_pc !== 16'h0 || issue_cnt !== 4'h0) begin
            failures++;
            $display("FAIL reset_data: instr=%h pc=%h cnt=%h want 0 0 0", instr, instr_pc, issue_cnt);
        end
        ack_addrs.delete();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            failures++;
            $display("FAIL reset_first_req: req=%b addr=%h want 1 0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_basic();
        int n;
        int t[2];
        logic [15:0] pcs[2];
        logic [15:0] ins[2];
        n = 0; t[0] = 0; t[1] = 0;
        pcs[0] = 16'hxxxx; pcs[1] = 16'hxxxx; ins[0] = 16'hxxxx; ins[1] = 16'hxxxx;
        ready = 1'b1; lat = 1;
        for (int cyc = 0; cyc < 40 && n < 2; cyc++) begin
            @(negedge clk);
            if (instr_valid && ready) begin
                pcs[n] = instr_pc; ins[n] = instr; t[n] = cyc; n++;
            end
        end
        @(negedge clk);
        ready = 1'b0;
        checks++;
        if (n != 2) begin failures++; $display("FAIL basic_timeout: issued=%0d want 2", n); end
        checks++;
        if (pcs[0] !== 16'h0000 || ins[0] !== 16'h1111) begin
            failures++; $display("FAIL basic_first: pc=%h instr=%h want 0000 1111", pcs[0], ins[0]);
        end
        checks++;
        if (pcs[1] !== 16'h0002 || ins[1] !== 16'h2222) begin
            failures++; $display("FAIL basic_second: pc=%h instr=%h want 0002 2222", pcs[1], ins[1]);
        end
        checks++;
        if (t[1] - t[0] != 3) begin
            failures++; $display("FAIL basic_throughput: cycles=%0d want 3", t[1] - t[0]);
        end
        checks++;
        if (ack_addrs.size() < 2 || ack_addrs[0] !== 16'h0000 || ack_addrs[1] !== 16'h0002) begin
            failures++; $display("FAIL basic_req_addrs: n=%0d want 0000,0002", ack_addrs.size());
        end
        checks++;
        if (issue_cnt !== 4'd2) begin failures++; $display("FAIL basic_count: cnt=%0d want 2", issue_cnt); end
    endtask

    task automatic test_hold();
        logic found;
        logic [15:0] hi, hp;
        logic [3:0] hc;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (instr_valid) begin found = 1'b1; break; end
        end
        checks++;
        if (!found || instr_pc !== 16'h0004 || instr !== mem_word(16'h0004)) begin
            failures++; $display("FAIL hold_offer: found=%b pc=%h instr=%h want 1 0004 %h", found, instr_pc, instr, mem_word(16'h0004));
        end
        hi = instr; hp = instr_pc; hc = issue_cnt;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instr !== hi || instr_pc !== hp || imem_req !== 1'b0 || issue_cnt !== hc) begin
                failures++;
                $display("FAIL hold_stable: valid=%b instr=%h pc=%h req=%b cnt=%0d want 1 %h %h 0 %0d", instr_valid, instr, instr_pc, imem_req, issue_cnt, hi, hp, hc);
            end
        end
        ready = 1'b1;
        @(negedge clk);
        checks++;
        if (issue_cnt !== 4'(hc + 4'd1)) begin
            failures++; $display("FAIL hold_accept: cnt=%0d want %0d", issue_cnt, 4'(hc + 4'd1));
        end
    endtask

    task automatic test_redirect_squash();
        logic [15:0] old_addr, fpc, fins;
        logic found;
        int bad;
        lat = 3; ready = 1'b1; found = 1'b0; bad = 0; fpc = 16'hxxxx; fins = 16'hxxxx;
        for (int c = 0; c < 20 && !(imem_req && !instr_valid); c++) @(negedge clk);
        old_addr = imem_addr;
        ack_addrs.delete();
        redirect = 1'b1; rpc = 16'h0105;
        @(negedge clk);
        redirect = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (ack_addrs.size() == 0 && (imem_req !== 1'b1 || imem_addr !== old_addr)) bad++;
            if (instr_valid) begin found = 1'b1; fpc = instr_pc; fins = instr; break; end
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL squash_req_stable: unstable_cycles=%0d want 0", bad); end
        checks++;
        if (!found || fpc !== 16'h0104 || fins !== mem_word(16'h0104)) begin
            failures++; $display("FAIL squash_issue: found=%b pc=%h instr=%h want 1 0104 %h", found, fpc, fins, mem_word(16'h0104));
        end
        checks++;
        if (ack_addrs.size() < 2 || ack_addrs[0] !== old_addr || ack_addrs[1] !== 16'h0104) begin
            failures++; $display("FAIL squash_refetch: n=%0d want %h then 0104", ack_addrs.size(), old_addr);
        end
    endtask

    task automatic test_halt_fetch();
        logic saw_valid, got_halt;
        logic [3:0] c0;
        lat = 3; ready = 1'b1; saw_valid = 1'b0; got_halt = 1'b0;
        for (int c = 0; c < 20 && !(imem_req && !instr_valid); c++) @(negedge clk);
        ack_addrs.delete();
        c0 = issue_cnt;
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (instr_valid) saw_valid = 1'b1;
            if (halted) begin got_halt = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!got_halt || saw_valid || imem_req !== 1'b0) begin
            failures++; $display("FAIL halt_fetch: halted=%b saw_valid=%b req=%b want 1 0 0", got_halt, saw_valid, imem_req);
        end
        checks++;
        if (ack_addrs.size() != 1 || issue_cnt !== c0) begin
            failures++; $display("FAIL halt_fetch_drain: acks=%0d cnt=%0d want 1 %0d", ack_addrs.size(), issue_cnt, c0);
        end
        redirect = 1'b1; rpc = 16'h0200;
        @(negedge clk);
        redirect = 1'b0;
        checks++;
        if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0200) begin
            failures++; $display("FAIL halt_fetch_exit: halted=%b req=%b addr=%h want 0 1 0200", halted, imem_req, imem_addr);
        end
    endtask

    task automatic test_halt_issue();
        logic found;
        logic [3:0] c1;
        lat = 1; ready = 1'b1; found = 1'b0;
        for (int c = 0; c < 20 && !instr_valid; c++) @(negedge clk);
        c1 = 4'(issue_cnt + 4'd1);
        halt = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            halt = 1'($urandom_range(0, 1));
            checks++;
            if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || issue_cnt !== c1) begin
                failures++;
                $display("FAIL halt_issue_hold: halted=%b req=%b valid=%b cnt=%0d want 1 0 0 %0d", halted, imem_req, instr_valid, issue_cnt, c1);
            end
            @(negedge clk);
        end
        halt = 1'b0;
        redirect = 1'b1; rpc = 16'h0040;
        @(negedge clk);
        redirect = 1'b0;
        checks++;
        if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
            failures++; $display("FAIL halt_issue_exit: halted=%b req=%b addr=%h want 0 1 0040", halted, imem_req, imem_addr);
        end
        for (int c = 0; c < 20; c++) begin
            if (instr_valid) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!found || instr_pc !== 16'h0040 || instr !== mem_word(16'h0040)) begin
            failures++; $display("FAIL halt_issue_resume: found=%b pc=%h want 1 0040", found, instr_pc);
        end
    endtask

    task automatic test_wrap_count();
        int n;
        logic [15:0] p0, p1;
        n = 0; p0 = 16'hxxxx; p1 = 16'hxxxx;
        rst_n = 1'b0; redirect = 1'b0; halt = 1'b0; ready = 1'b1; lat = 1;
        repeat (2) @(negedge clk);
        ack_addrs.delete();
        rst_n = 1'b1; redirect = 1'b1; rpc = 16'hFFFE;
        @(negedge clk);
        redirect = 1'b0;
        for (int c = 0; c < 200 && n < 17; c++) begin
            @(negedge clk);
            if (instr_valid && ready) begin
                if (n == 0) p0 = instr_pc;
                if (n == 1) p1 = instr_pc;
                n++;
            end
        end
        @(negedge clk);
        ready = 1'b0;
        checks++;
        if (p0 !== 16'hFFFE || p1 !== 16'h0000) begin
            failures++; $display("FAIL wrap_pc: pcs=%h,%h want FFFE,0000", p0, p1);
        end
        checks++;
        if (ack_addrs.size() < 2 || ack_addrs[0] !== 16'hFFFE || ack_addrs[1] !== 16'h0000) begin
            failures++; $display("FAIL wrap_req_addr: n=%0d want FFFE,0000", ack_addrs.size());
        end
        checks++;
        if (n != 17 || issue_cnt !== 4'd1) begin
            failures++; $display("FAIL wrap_count: accepts=%0d cnt=%0d want 17 1", n, issue_cnt);
        end
    endtask

    task automatic test_async_reset();
        lat = 3; ready = 1'b1;
        for (int c = 0; c < 20 && !(imem_req && !instr_valid); c++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 ||
            instr !== 16'h0 || instr_pc !== 16'h0 || issue_cnt !== 4'h0) begin
            failures++;
            $display("FAIL async_reset: req=%b valid=%b halted=%b instr=%h pc=%h cnt=%0d want all 0", imem_req, instr_valid, halted, instr, instr_pc, issue_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            failures++; $display("FAIL async_release: req=%b addr=%h want 1 0000", imem_req, imem_addr);
        end
    endtask

    // Program-order model: every offered instruction sits at the expected pc
    task automatic test_random();
        logic [15:0] exp_pc, hold_i, hold_p;
        logic [3:0] exp_cnt;
        logic want_low, want_hold;
        int hs;
        exp_pc = 16'h0000; exp_cnt = 4'd0; want_low = 1'b0; want_hold = 1'b0;
        hold_i = 16'h0; hold_p = 16'h0; hs = 0;
        for (int c = 0; c < 1000; c++) begin
            checks++;
            if (issue_cnt !== exp_cnt) begin
                failures++; $display("FAIL rand_count: cyc=%0d cnt=%0d want %0d", c, issue_cnt, exp_cnt);
            end
            if (instr_valid) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
                    failures++; $display("FAIL rand_order: cyc=%0d pc=%h instr=%h want %h %h", c, instr_pc, instr, exp_pc, mem_word(exp_pc));
                end
            end
            if (want_low) begin
                checks++;
                if (instr_valid !== 1'b0) begin
                    failures++; $display("FAIL rand_redirect_drop: cyc=%0d valid=%b want 0", c, instr_valid);
                end
            end
            if (want_hold) begin
                checks++;
                if (instr_valid !== 1'b1 || instr !== hold_i || instr_pc !== hold_p) begin
                    failures++; $display("FAIL rand_hold: cyc=%0d valid=%b instr=%h pc=%h want 1 %h %h", c, instr_valid, instr, instr_pc, hold_i, hold_p);
                end
            end
            checks++;
            if ((imem_req && instr_valid) || halted !== 1'b0) begin
                failures++; $display("FAIL rand_exclusive: cyc=%0d req=%b valid=%b halted=%b", c, imem_req, instr_valid, halted);
            end
            ready = ($urandom_range(0, 99) < 60);
            redirect = ($urandom_range(0, 99) < 8);
            rpc = 16'($urandom);
            lat = int'($urandom_range(1, 3));
            if (instr_valid && ready) begin
                hs++;
                exp_cnt = 4'(exp_cnt + 4'd1);
                exp_pc = 16'(exp_pc + 16'd2);
            end
            if (redirect) exp_pc = rpc & 16'hFFFE;
            want_low = redirect;
            want_hold = instr_valid && !ready && !redirect;
            hold_i = instr; hold_p = instr_pc;
            @(negedge clk);
        end
        ready = 1'b0; redirect = 1'b0;
        checks++;
        if (hs < 50) begin failures++; $display("FAIL rand_progress: accepts=%0d want >=50", hs); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_redirect_squash();
        test_halt_fetch();
        test_halt_issue();
        test_wrap_count();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
